// File: rtl/stick_pkg.sv
// Shared encodings and geometry for the stick game round logic.
// The renderer uses the same state encodings and screen limits.
package stick_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        GROW   = 3'd1,
        FALL   = 3'd2,
        WALK   = 3'd3,
        SCROLL = 3'd4,
        DROP   = 3'd5,
        OVER   = 3'd6
    } state_t;

    // visible area in hCount/vCount space
    localparam int H_MIN = 144;
    localparam int H_MAX = 783;
    localparam int V_MIN = 35;
    localparam int V_MAX = 515;

    localparam int STICK_X_D    = 450;
    localparam int HERO_X0_D    = 440;
    localparam int HERO_Y0_D    = 250;
    localparam int GROW_STEP_D  = 2;
    localparam int MAX_LEN_D    = 216;
    localparam int FALL_TICKS_D = 8;
    localparam int WALK_STEP_D  = 4;
    localparam int DROP_STEP_D  = 8;

endpackage

// File: rtl/stick_btn_edge.sv
// Rising-edge detector for the up button, advanced only on game ticks.
// press is valid only during a tick cycle.
module stick_btn_edge (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic btn,
    output logic press
);

    logic btn_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            btn_q <= 1'b0;
        else if (tick)
            btn_q <= btn;
    end

    assign press = tick & btn & ~btn_q;

endmodule

// File: rtl/stick_round_fsm.sv
// Round sequencer: grow, fall, walk, then scroll or drop, on the game tick.
// Owns stick length, hero position, score and game-over state.
module stick_round_fsm
    import stick_pkg::*;
#(
    parameter int STICK_X    = STICK_X_D,
    parameter int HERO_X0    = HERO_X0_D,
    parameter int HERO_Y0    = HERO_Y0_D,
    parameter int BOTTOM_Y   = V_MAX,
    parameter int GROW_STEP  = GROW_STEP_D,
    parameter int MAX_LEN    = MAX_LEN_D,
    parameter int FALL_TICKS = FALL_TICKS_D,
    parameter int WALK_STEP  = WALK_STEP_D,
    parameter int DROP_STEP  = DROP_STEP_D
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       btn,
    input  logic [9:0] plat_left,
    input  logic [9:0] plat_right,
    output logic [9:0] stick_len,
    output logic       stick_down,
    output logic [9:0] hero_x,
    output logic [9:0] hero_y,
    output logic [7:0] score,
    output logic [2:0] state,
    output logic       new_platform,
    output logic       game_over
);

    state_t      st_q, st_d;
    logic [9:0]  len_q, len_d;
    logic [9:0]  x_q, x_d;
    logic [9:0]  y_q, y_d;
    logic        down_q, down_d;
    logic [7:0]  score_q, score_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        hit_q, hit_d;
    logic [10:0] tgt_q, tgt_d;
    logic        np_q, np_d;
    logic        press;

    logic [10:0] tip, len_sum, x_sum, y_sum;
    logic        tip_hit;

    stick_btn_edge u_btn (
        .clk   (clk),
        .rst   (rst),
        .tick  (tick),
        .btn   (btn),
        .press (press)
    );

    // 11-bit arithmetic so sums never wrap before saturation
    assign tip     = 11'(STICK_X) + {1'b0, len_q};
    assign len_sum = {1'b0, len_q} + 11'(GROW_STEP);
    assign x_sum   = {1'b0, x_q} + 11'(WALK_STEP);
    assign y_sum   = {1'b0, y_q} + 11'(DROP_STEP);
    assign tip_hit = (tip >= {1'b0, plat_left}) &&
                     (tip <= {1'b0, plat_right});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q    <= IDLE;
            len_q   <= '0;
            x_q     <= 10'(HERO_X0);
            y_q     <= 10'(HERO_Y0);
            down_q  <= 1'b0;
            score_q <= '0;
            cnt_q   <= '0;
            hit_q   <= 1'b0;
            tgt_q   <= '0;
            np_q    <= 1'b0;
        end else begin
            st_q    <= st_d;
            len_q   <= len_d;
            x_q     <= x_d;
            y_q     <= y_d;
            down_q  <= down_d;
            score_q <= score_d;
            cnt_q   <= cnt_d;
            hit_q   <= hit_d;
            tgt_q   <= tgt_d;
            np_q    <= np_d;
        end
    end

    always_comb begin
        st_d    = st_q;
        len_d   = len_q;
        x_d     = x_q;
        y_d     = y_q;
        down_d  = down_q;
        score_d = score_q;
        cnt_d   = cnt_q;
        hit_d   = hit_q;
        tgt_d   = tgt_q;
        np_d    = 1'b0;
        if (tick) begin
            case (st_q)
                IDLE: begin
                    if (press) begin
                        st_d  = GROW;
                        len_d = 10'(GROW_STEP);
                    end
                end
                GROW: begin
                    if (btn) begin
                        len_d = (len_sum >= 11'(MAX_LEN)) ?
                                10'(MAX_LEN) : len_sum[9:0];
                    end else begin
                        st_d  = FALL;
                        cnt_d = '0;
                    end
                end
                FALL: begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_q == 8'(FALL_TICKS - 1)) begin
                        st_d   = WALK;
                        down_d = 1'b1;
                        hit_d  = tip_hit;
                        // platform edges are only valid at this tick
                        tgt_d  = tip_hit ? {1'b0, plat_right} : tip;
                    end
                end
                WALK: begin
                    if ({1'b0, x_q} == tgt_q)
                        st_d = hit_q ? SCROLL : DROP;
                    else
                        x_d = (x_sum >= tgt_q) ? tgt_q[9:0] : x_sum[9:0];
                end
                SCROLL: begin
                    st_d    = IDLE;
                    score_d = (score_q == 8'hFF) ? score_q : score_q + 8'd1;
                    len_d   = '0;
                    down_d  = 1'b0;
                    x_d     = 10'(HERO_X0);
                    np_d    = 1'b1;
                end
                DROP: begin
                    if (y_q == 10'(BOTTOM_Y))
                        st_d = OVER;
                    else
                        y_d = (y_sum >= 11'(BOTTOM_Y)) ?
                              10'(BOTTOM_Y) : y_sum[9:0];
                end
                OVER: begin
                    if (press) begin
                        st_d    = IDLE;
                        score_d = '0;
                        len_d   = '0;
                        down_d  = 1'b0;
                        x_d     = 10'(HERO_X0);
                        y_d     = 10'(HERO_Y0);
                        np_d    = 1'b1;
                    end
                end
                default: st_d = IDLE;
            endcase
        end
    end

    assign stick_len    = len_q;
    assign stick_down   = down_q;
    assign hero_x       = x_q;
    assign hero_y       = y_q;
    assign score        = score_q;
    assign state        = st_q;
    assign new_platform = np_q;
    assign game_over    = (st_q == OVER);

endmodule
